// File: rtl/demux4_route_buf.sv
// 1-to-4 buffered router: one word plus a 2-bit destination select, delivered in order to one of four sinks.
// A two-entry buffer (output stage plus skid) keeps full throughput with a registered upstream ready.
// Optional per-destination fire counters are enabled by defining DEMUX_STATS_EN.
//
// state | meaning
// EMPTY | no entry held
// ONE   | output stage holds a word, skid empty
// TWO   | output stage and skid both hold words; upstream stalled
module demux4_route_buf #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              iClk,
    input  logic              iRst_n,
    input  logic              iValid,
    output logic              oReady,
    input  logic [DATA_W-1:0] iData,
    input  logic [1:0]        iS,
    output logic [3:0]        oValid,
    input  logic [3:0]        iReady,
    output logic [DATA_W-1:0] oData,
    output logic [1:0]        oSel,
`ifdef DEMUX_STATS_EN
    input  logic              iClrCnt,
    output logic [4*CNT_W-1:0] oCount,
`endif
    output logic              oBusy
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stateT;

    stateT             state;
    stateT             stateNext;
    logic [DATA_W-1:0] outData;
    logic [1:0]        outSel;
    logic [DATA_W-1:0] skidData;
    logic [1:0]        skidSel;
    logic              outValid;
    logic              acc;
    logic              fire;
    logic              loadOutFromIn;
    logic              loadOutFromSkid;
    logic              loadSkid;

    // Valids are decoded from state so oReady has no path from iReady/iValid.
    assign outValid = (state != EMPTY);
    assign oReady   = (state != TWO);
    assign oBusy    = outValid;
    assign oData    = outData;
    assign oSel     = outSel;
    assign oValid   = outValid ? (4'b0001 << outSel) : 4'b0000;

    assign acc  = iValid && oReady;
    assign fire = outValid && iReady[outSel];

    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state    <= EMPTY;
            outData  <= '0;
            outSel   <= '0;
            skidData <= '0;
            skidSel  <= '0;
        end else begin
            state <= stateNext;
            if (loadOutFromIn) begin
                outData <= iData;
                outSel  <= iS;
            end else if (loadOutFromSkid) begin
                outData <= skidData;
                outSel  <= skidSel;
            end
            if (loadSkid) begin
                skidData <= iData;
                skidSel  <= iS;
            end
        end
    end

    always_comb begin
        stateNext       = state;
        loadOutFromIn   = 1'b0;
        loadOutFromSkid = 1'b0;
        loadSkid        = 1'b0;
        case (state)
            EMPTY: begin
                if (acc) begin
                    loadOutFromIn = 1'b1;
                    stateNext     = ONE;
                end
            end
            ONE: begin
                if (fire && acc) begin
                    loadOutFromIn = 1'b1;
                end else if (fire) begin
                    stateNext = EMPTY;
                end else if (acc) begin
                    loadSkid  = 1'b1;
                    stateNext = TWO;
                end
            end
            TWO: begin
                if (fire) begin
                    loadOutFromSkid = 1'b1;
                    stateNext       = ONE;
                end
            end
            default: stateNext = EMPTY;
        endcase
    end

`ifdef DEMUX_STATS_EN
    logic [CNT_W-1:0] fireCnt [4];

    // A clear wins over a fire in the same cycle.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            for (int k = 0; k < 4; k++) fireCnt[k] <= '0;
        end else if (iClrCnt) begin
            for (int k = 0; k < 4; k++) fireCnt[k] <= '0;
        end else if (fire) begin
            fireCnt[outSel] <= fireCnt[outSel] + 1'b1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : genCount
        assign oCount[g*CNT_W +: CNT_W] = fireCnt[g];
    end
`endif

endmodule

// File: doc/demux4_route_buf.md
Name: demux4_route_buf

Overview:
- 1-to-4 buffered router: the inverse of the datapath 4:1 selectors. Takes one 32-bit word plus a 2-bit destination select and delivers it to exactly one of four sinks (e.g. DMEM, LED, seven-seg, UART store ports).
- Valid/ready handshake on both sides.
- Two-entry buffer (output stage plus skid) gives full throughput with a registered upstream ready.
- Strict in-order delivery; head-of-line blocking is intended.

Parameters:
- DATA_W, 32, width of the routed data word.
- CNT_W, 16, width of each per-port transfer counter (used only with DEMUX_STATS_EN).

Ports:
- iClk  input  1  system clock, rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iValid  input  1  upstream word valid.
- oReady  output  1  block can accept a word this cycle.
- iData  input  DATA_W  upstream word.
- iS  input  2  destination select, 0..3.
- oValid  output  4  one-hot per-destination valid; all zero when empty.
- iReady  input  4  per-destination ready.
- oData  output  DATA_W  word broadcast to all destinations; qualified by oValid.
- oSel  output  2  destination of the word currently presented.
- oBusy  output  1  high when any entry is held.

Behaviour:
- Storage: OUT stage {valid, data, sel} drives oData, oSel and oValid. SKID stage {valid, data, sel} is internal.
- Output signals:
  - oReady = !SKID.valid, decoded from state only. No combinational path from iReady or iValid.
  - oValid[k] = OUT.valid && (OUT.sel == k).
  - oBusy = OUT.valid.
- Events:
  - acc = iValid && oReady.
  - fire = OUT.valid && iReady[OUT.sel]. iReady bits of non-selected ports are ignored.
- States are derived from the valids: EMPTY (none), ONE (OUT only), TWO (OUT+SKID).
- EMPTY:
  - acc: OUT <= {1, iData, iS}; go to ONE.
  - otherwise: stay in EMPTY.
- ONE:
  - fire && acc: OUT <= input word; stay in ONE.
  - fire only: go to EMPTY.
  - acc only: SKID <= input word; go to TWO.
  - neither: hold.
- TWO (oReady=0):
  - fire: OUT <= SKID, SKID.valid <= 0; go to ONE.
  - otherwise: hold.
- Latency: a word accepted at edge N is presented on oValid after edge N (1 cycle).
- Sustained throughput: 1 word/cycle when the selected sink holds iReady high.
- Stability: while oValid[k]=1 and iReady[k]=0, oData, oSel and oValid hold constant.
- Deadlock: a sink that never asserts ready stalls the block indefinitely. No timeout, no drop.
- Reset (async assert, release synchronous to iClk):
  - All valids 0, data/sel registers 0.
  - Resulting outputs: oValid=0, oData=0, oSel=0, oBusy=0, oReady=1.
- Reset mid-transfer discards both entries. No partial delivery.
- iS is sampled only on acc. iS/iData are don't-care when iValid=0.

Optional Feature:
- Macro: DEMUX_STATS_EN.
- When defined:
  - Adds input iClrCnt (1) and output oCount (4*CNT_W).
  - oCount[k*CNT_W +: CNT_W] counts fires to destination k.
  - Counters wrap at 2^CNT_W-1 -> 0.
  - iClrCnt synchronously zeroes all counters; a fire in the same cycle is not counted.
  - Counters reset to 0 on iRst_n.
- When undefined: those ports and counters do not exist; behaviour is otherwise identical.

Test Plan:
- Reset then idle -> oReady=1, oValid=4'b0000, oBusy=0, oData=0.
- Send 0xDEAD_BEEF with iS=2, iReady=4'b1111 -> next cycle oValid=4'b0100, oData=0xDEADBEEF, oSel=2; then empty.
- Stream 8 words with iS cycling 0,1,2,3, all iReady=1 -> 8 consecutive delivery cycles in order, correct one-hot each cycle, oReady stays 1.
- Send A(iS=1), B(iS=3) with iReady=0 -> after 2 accepts oReady=0. Raise iReady[3] only -> A held, no progress. Raise iReady[1] -> A delivered, then B on oValid=4'b1000.
- Assert iRst_n=0 mid-cycle with TWO entries held -> outputs clear immediately. After release oReady=1 and neither held word is ever delivered.
- With DEMUX_STATS_EN, CNT_W=4: 17 fires to port 0 -> oCount[3:0]=1. Pulse iClrCnt -> all four counters 0.
